// File: rtl/fir_sample_fifo.sv
// Output stage behind the 8-bit FIR filter: optional decimation, FWFT FIFO, sticky overflow.
// Optional almost_full output is enabled by defining FIFO_ALMOST_FULL_EN.
module fir_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DECIM = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic          almost_full
`endif
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [3:0]  DCNT_LAST = 4'(DECIM - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [3:0]    dcnt_reg, dcnt_next;
    logic          overflow_reg, overflow_next;

    logic push, pop, full, empty, wr_en, drop;

    always_comb begin
        empty = (count_reg == '0);
        full  = (count_reg == FULL_CNT);
        push  = in_valid && (dcnt_reg == 4'd0);
        pop   = !empty && out_ready;
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        dcnt_next = dcnt_reg;
        if (in_valid) begin
            dcnt_next = (dcnt_reg == DCNT_LAST) ? 4'd0 : dcnt_reg + 4'd1;
        end

        wr_ptr_next = wr_en ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop   ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!wr_en && pop) begin
            count_next = count_reg - 1'b1;
        end

        // A drop wins over a simultaneous clear.
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            dcnt_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            dcnt_reg     <= dcnt_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; each entry loads only when addressed by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : mem[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_CNT = (AW+1)'(DEPTH - 2);
    logic almost_full_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (count_next >= AF_CNT);
        end
    end

    assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: main instance with DECIM=1, second instance with DECIM=3.
module tb_fir_sample_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, clr_ovf;
    logic [7:0] in_data;
    logic       out_valid, overflow;
    logic [7:0] out_data;
    logic [3:0] count;

    logic       d_valid, d_ready, d_clr;
    logic [7:0] d_data;
    logic       d_out_valid, d_overflow;
    logic [7:0] d_out_data;
    logic [3:0] d_count;

`ifdef FIFO_ALMOST_FULL_EN
    logic       almost_full, d_almost_full;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_sample_fifo #(.DEPTH(8), .AW(3), .DECIM(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef FIFO_ALMOST_FULL_EN
        , .almost_full(almost_full)
`endif
    );

    fir_sample_fifo #(.DEPTH(8), .AW(3), .DECIM(3)) u_dec (
        .clk(clk), .rst(rst),
        .in_valid(d_valid), .in_data(d_data),
        .out_valid(d_out_valid), .out_ready(d_ready), .out_data(d_out_data),
        .count(d_count), .overflow(d_overflow), .clr_ovf(d_clr)
`ifdef FIFO_ALMOST_FULL_EN
        , .almost_full(d_almost_full)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int n;
    logic [7:0] dec_exp [3];

    initial begin
        rst = 1'b0;
        in_valid = 0; in_data = 0; out_ready = 0; clr_ovf = 0;
        d_valid = 0; d_data = 0; d_ready = 1; d_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_count", count, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_data", out_data, 0);
        rst = 1'b1;
        tick;

        // Streaming with consumer always ready
        out_ready = 1;
        in_valid = 1; in_data = 8'h05; tick;
        check_val("t1_d05", out_data, 8'h05); check_val("t1_c1", count, 1);
        in_data = 8'hFE; tick;
        check_val("t1_dFE", out_data, 8'hFE); check_val("t1_c2", count, 1);
        in_data = 8'h7F; tick;
        check_val("t1_d7F", out_data, 8'h7F); check_val("t1_c3", count, 1);
        in_valid = 0; tick;
        check_val("t1_empty", out_valid, 0);
        check_val("t1_ovf", overflow, 0);

        // Overfill with consumer stalled
        out_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1; in_data = 8'(i); tick;
        end
        in_valid = 0;
        check_val("t2_count", count, 8);
        check_val("t2_ovf", overflow, 1);
        tick;
        check_val("t2_stable", out_data, 8'h01);
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            check_val("t2_drain", out_data, 32'(i));
            tick;
        end
        check_val("t2_empty", out_valid, 0);
        check_val("t2_empty_c", count, 0);
        out_ready = 0;

        // Full FIFO: simultaneous push and pop
        clr_ovf = 1; tick; clr_ovf = 0;
        check_val("t3_clr", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 8'(8'h21 + i); tick;
        end
        check_val("t3_full", count, 8);
        in_valid = 1; in_data = 8'h33; out_ready = 1;
        check_val("t3_head", out_data, 8'h21);
        tick;
        in_valid = 0;
        check_val("t3_count", count, 8);
        check_val("t3_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) begin
            check_val("t3_drain", out_data, 32'(8'h22 + i));
            tick;
        end
        check_val("t3_last", out_data, 8'h33);
        tick;
        check_val("t3_empty", out_valid, 0);
        out_ready = 0;

        // Overflow clear, then clear racing a drop
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; in_data = 8'(8'h40 + i); tick;
        end
        in_valid = 0;
        check_val("t5_ovf_set", overflow, 1);
        clr_ovf = 1; tick; clr_ovf = 0;
        check_val("t5_ovf_clr", overflow, 0);
        in_valid = 1; in_data = 8'h4A; clr_ovf = 1; tick;
        in_valid = 0; clr_ovf = 0;
        check_val("t5_set_wins", overflow, 1);
        check_val("t5_count", count, 8);
        check_val("t5_head", out_data, 8'h40);

        // Drain to 5 entries, then asynchronous reset mid-cycle
        out_ready = 1; tick; tick; tick; out_ready = 0;
        check_val("t6_count5", count, 5);
        rst = 1'b0;
        #2;
        check_val("t6_valid", out_valid, 0);
        check_val("t6_count", count, 0);
        check_val("t6_ovf", overflow, 0);
        #2;
        rst = 1'b1;
        tick;
        in_valid = 1; in_data = 8'h5A; tick;
        in_valid = 0;
        check_val("t6_valid1", out_valid, 1);
        check_val("t6_data", out_data, 8'h5A);
        check_val("t6_count1", count, 1);

        // Decimation by 3
        dec_exp[0] = 8'h10; dec_exp[1] = 8'h13; dec_exp[2] = 8'h16;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            d_valid = 1; d_data = 8'(8'h10 + i); tick;
            if (d_out_valid) begin
                if (n < 3) check_val("t4_dec", d_out_data, dec_exp[n]);
                n++;
            end
        end
        d_valid = 0; tick;
        if (d_out_valid) n++;
        check_val("t4_kept", n, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
